// File: rtl/pdm_audio_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pdm_audio_pkg : shared sizing and state encoding for pdm_pcm_pwm     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pdm_audio_pkg;

    localparam int FRAME_W    = 128;
    localparam int CHUNK_W    = 8;
    localparam int PWM_BITS   = 8;
    localparam int FIFO_DEPTH = 4;

    localparam int ACC_W    = $clog2(FRAME_W) + 1;
    localparam int LVL_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int N_CHUNKS = FRAME_W / CHUNK_W;
    localparam int IDX_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam int SCALE_SH = PWM_BITS - $clog2(FRAME_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        PUSH  = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sample_fifo : synchronous FIFO, read-before-write when full,         |
// | occupancy output and a write-dropped pulse.  Rev 1.0                 |
// +----------------------------------------------------------------------+
module sample_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     empty_o,
    output logic                     wr_drop_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             full;
    logic             do_rd;
    logic             do_wr;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty_o   = (level_q == '0);
    assign full      = (level_q == LW'(DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_rd     = rd_en_i & ~empty_o;
    assign do_wr     = wr_en_i & (~full | do_rd);
    assign wr_drop_o = wr_en_i & ~do_wr;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign level_o   = level_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= bump(wr_ptr_q);
            if (do_rd) rd_ptr_q <= bump(rd_ptr_q);
            level_q <= level_q + LW'(do_wr) - LW'(do_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule
`default_nettype wire

// File: rtl/pdm_pcm_pwm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pdm_pcm_pwm : PDM frame -> ones-count PCM sample -> FIFO -> PWM pin  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pdm_pcm_pwm
    import pdm_audio_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [FRAME_W-1:0]  frame,
    input  logic                done,
    output logic                pwm_out,
    output logic [PWM_BITS-1:0] sample,
    output logic                sample_valid,
    output logic [LVL_W-1:0]    fifo_level,
    output logic                busy,
    output logic                overrun,
    output logic                underrun
);
    localparam int SC_W = PWM_BITS + 1;

    state_e              state_q, state_d;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [PWM_BITS-1:0] sample_q, sample_d;
    logic                valid_q, valid_d;
    logic                done_q;

    logic [ACC_W-1:0]    chunk_ones;
    logic [ACC_W-1:0]    acc_sum;
    logic [SC_W-1:0]     scaled;
    logic [PWM_BITS-1:0] sat_sample;
    logic                start_edge;
    logic                frame_drop;
    logic                fifo_wr;

    logic [PWM_BITS-1:0] cnt_q;
    logic [PWM_BITS-1:0] duty_q;
    logic                pwm_q;
    logic                over_q;
    logic                under_q;
    logic                wrap;
    logic                fifo_empty;
    logic                fifo_drop;
    logic [PWM_BITS-1:0] fifo_rd_data;

    assign start_edge = done & ~done_q;

    // The latched frame is shifted down each COUNT cycle, so the low chunk is always next.
    always_comb begin
        chunk_ones = '0;
        for (int i = 0; i < CHUNK_W; i++) begin
            chunk_ones = chunk_ones + ACC_W'(frame_q[i]);
        end
    end

    assign acc_sum    = acc_q + chunk_ones;
    assign scaled     = SC_W'(acc_sum) << SCALE_SH;
    assign sat_sample = scaled[PWM_BITS] ? '1 : scaled[PWM_BITS-1:0];

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        sample_d   = sample_q;
        valid_d    = 1'b0;
        fifo_wr    = 1'b0;
        frame_drop = start_edge & (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    frame_d = frame;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                frame_d = frame_q >> CHUNK_W;
                acc_d   = acc_sum;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(N_CHUNKS - 1)) begin
                    sample_d = sat_sample;
                    valid_d  = 1'b1;
                    state_d  = PUSH;
                end
            end
            PUSH: begin
                fifo_wr = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            frame_q  <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            frame_q  <= frame_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            done_q   <= done;
        end
    end

    sample_fifo #(
        .WIDTH (PWM_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (fifo_wr),
        .wr_data_i (sample_q),
        .rd_en_i   (wrap),
        .rd_data_o (fifo_rd_data),
        .level_o   (fifo_level),
        .empty_o   (fifo_empty),
        .wr_drop_o (fifo_drop)
    );

    assign wrap = (cnt_q == '1);

    // Duty is only reloaded on the last count of a period, so each period is glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            duty_q  <= '0;
            pwm_q   <= 1'b0;
            over_q  <= 1'b0;
            under_q <= 1'b0;
        end else begin
            cnt_q <= cnt_q + PWM_BITS'(1);
            pwm_q <= (cnt_q < duty_q);
            if (wrap) begin
                if (!fifo_empty) duty_q  <= fifo_rd_data;
                else             under_q <= 1'b1;
            end
            if (frame_drop || fifo_drop) over_q <= 1'b1;
        end
    end

    assign pwm_out      = pwm_q;
    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign busy         = (state_q != IDLE);
    assign overrun      = over_q;
    assign underrun     = under_q;

endmodule
`default_nettype wire
